motor_pwm: RTL and testbench

Two-channel H-bridge PWM generator clocked by the prescaler enable. Consumes the one-cycle `tick` from the clock divider and advances one PWM step per tick. Duty, period and direction are double-buffered and take effect only at a period boundary. A programmable dead time is inserted on direction reversal so both bridge legs are never driven together.

---
 rtl/motor_pwm_if.sv | 25 ++
 rtl/motor_pwm.sv | 115 +++++++++++
 tb/tb_motor_pwm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/motor_pwm_if.sv
// Control/status bundle for the H-bridge PWM generator: tick, shadow-load
// inputs and the registered bridge outputs.
interface motor_pwm_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic [WIDTH-1:0] period_in;
  logic [WIDTH-1:0] duty_in;
  logic             dir_in;
  logic             load;
  logic             pending;
  logic             out_a;
  logic             out_b;
  logic             cycle_start;

  modport master (
    output tick, period_in, duty_in, dir_in, load,
    input  pending, out_a, out_b, cycle_start
  );

  modport slave (
    input  tick, period_in, duty_in, dir_in, load,
    output pending, out_a, out_b, cycle_start
  );
endinterface

// File: rtl/motor_pwm.sv
// Two-channel H-bridge PWM: one step per divider tick, double-buffered
// period/duty/direction, and a dead-time gap when the direction reverses.
module motor_pwm #(
  parameter int WIDTH    = 8,
  parameter int DEADTIME = 2
) (
  input  logic        clk,
  input  logic        reset,
  motor_pwm_if.slave  bus
);

  localparam int       DW       = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam bit       HAS_DEAD = (DEADTIME > 0);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] DEAD   = 1'b1;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_per_act;
  logic [WIDTH-1:0] r_duty_act;
  logic             r_dir_act;
  logic [WIDTH-1:0] r_per_sh;
  logic [WIDTH-1:0] r_duty_sh;
  logic             r_dir_sh;
  logic             r_pending;
  logic [0:0]       r_state;
  logic [DW-1:0]    r_dcnt;
  logic             r_out_a;
  logic             r_out_b;
  logic             r_cycle_start;

  logic             w_wrap;
  logic             w_apply;
  logic [WIDTH-1:0] w_per_nxt;
  logic [WIDTH-1:0] w_duty_nxt;
  logic             w_dir_nxt;
  logic             w_dir_chg;
  logic             w_pwm;

  // >= rather than == so a period shrunk below the running count still wraps
  assign w_wrap = bus.tick && (r_cnt >= r_per_act);

  // A load landing on the wrap tick bypasses the shadow and goes live at once
  always_comb begin
    w_apply    = w_wrap && (bus.load || r_pending);
    w_per_nxt  = r_per_sh;
    w_duty_nxt = r_duty_sh;
    w_dir_nxt  = r_dir_sh;
    if (bus.load) begin
      w_per_nxt  = bus.period_in;
      w_duty_nxt = bus.duty_in;
      w_dir_nxt  = bus.dir_in;
    end
  end

  assign w_dir_chg = HAS_DEAD && w_apply && (w_dir_nxt != r_dir_act);
  assign w_pwm     = {1'b0, r_cnt} < {1'b0, r_duty_act};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_per_act     <= '0;
      r_duty_act    <= '0;
      r_dir_act     <= 1'b0;
      r_per_sh      <= '0;
      r_duty_sh     <= '0;
      r_dir_sh      <= 1'b0;
      r_pending     <= 1'b0;
      r_state       <= RUN;
      r_dcnt        <= '0;
      r_out_a       <= 1'b0;
      r_out_b       <= 1'b0;
      r_cycle_start <= 1'b0;
    end else begin
      if (bus.tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end

      if (bus.load) begin
        r_per_sh  <= bus.period_in;
        r_duty_sh <= bus.duty_in;
        r_dir_sh  <= bus.dir_in;
      end

      if (w_apply) begin
        r_per_act  <= w_per_nxt;
        r_duty_act <= w_duty_nxt;
        r_dir_act  <= w_dir_nxt;
        r_pending  <= 1'b0;
      end else if (bus.load) begin
        r_pending  <= 1'b1;
      end

      // Dead time runs on ticks while cnt keeps going, so it eats into the period
      if (w_dir_chg) begin
        r_state <= DEAD;
        r_dcnt  <= DW'(DEADTIME);
      end else if ((r_state == DEAD) && bus.tick) begin
        if (r_dcnt == DW'(1)) begin
          r_state <= RUN;
        end
        r_dcnt <= r_dcnt - 1'b1;
      end

      r_out_a       <= w_pwm && !r_dir_act && (r_state == RUN);
      r_out_b       <= w_pwm &&  r_dir_act && (r_state == RUN);
      r_cycle_start <= w_wrap;
    end
  end

  assign bus.pending     = r_pending;
  assign bus.out_a       = r_out_a;
  assign bus.out_b       = r_out_b;
  assign bus.cycle_start = r_cycle_start;

endmodule

// File: tb/tb_motor_pwm.sv
// Directed bench for motor_pwm: tick every 4 clk, period 9 (40 clk per PWM
// period), windows aligned on cycle_start and compared with hand-derived counts.
module tb_motor_pwm;

  logic clk;
  logic reset;
  bit   tick_on = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;

  motor_pwm_if #(.WIDTH(8)) bus ();

  motor_pwm #(.WIDTH(8), .DEADTIME(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : tick_gen
    int dc;
    dc       = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!tick_on) begin
        bus.tick = 1'b0;
        dc       = 0;
      end else begin
        bus.tick = (dc == 3);
        dc       = (dc == 3) ? 0 : dc + 1;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.cycle_start) seen = 1'b1;
    end
    check({tag, "_cs_seen"}, int'(seen), 1);
  endtask

  // One 40-clk PWM period starting at the sample where cycle_start is high.
  // Up to two loads (period 9) are injected at samples k1/k2 (negative = none).
  task automatic win(input int idx,
                     input int k1, input int d1, input int r1,
                     input int k2, input int d2, input int r2,
                     input int exp_ha, input int exp_hb, input int exp_pm);
    int    ha, hb, both;
    logic  pm;
    string t;
    ha = 0; hb = 0; both = 0; pm = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ha   += int'(bus.out_a);
      hb   += int'(bus.out_b);
      both += int'(bus.out_a & bus.out_b);
      if (k == 30) pm = bus.pending;
      bus.load = 1'b0;
      if (k == k1) begin
        bus.period_in = 8'd9; bus.duty_in = 8'(d1); bus.dir_in = r1[0]; bus.load = 1'b1;
      end
      if (k == k2) begin
        bus.period_in = 8'd9; bus.duty_in = 8'(d2); bus.dir_in = r2[0]; bus.load = 1'b1;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    t = $sformatf("W%0d", idx);
    check({t, "_out_a_high"}, ha, exp_ha);
    check({t, "_out_b_high"}, hb, exp_hb);
    check({t, "_both_high"}, both, 0);
    check({t, "_pending_mid"}, int'(pm), exp_pm);
    check({t, "_cs_at_40"}, int'(bus.cycle_start), 1);
    check({t, "_pending_end"}, int'(bus.pending), 0);
  endtask

  initial begin : main
    int ha, hb, ncs;
    reset         = 1'b0;
    bus.load      = 1'b0;
    bus.period_in = '0;
    bus.duty_in   = '0;
    bus.dir_in    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_a", int'(bus.out_a), 0);
    check("rst_out_b", int'(bus.out_b), 0);
    check("rst_cycle_start", int'(bus.cycle_start), 0);
    check("rst_pending", int'(bus.pending), 0);
    reset = 1'b1;

    @(negedge clk);
    bus.period_in = 8'd9; bus.duty_in = 8'd3; bus.dir_in = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("load_sets_pending", int'(bus.pending), 1);
    tick_on = 1'b1;
    repeat (8) @(negedge clk);
    check("first_wrap_applies", int'(bus.pending), 0);
    wait_cs("sync");

    // basic duty 3/10, no loads
    win(1, -1, 0, 0, -1, 0, 0, 12, 0, 0);
    // double buffering: duty 5 then 7 mid-period, old duty 3 still seen
    win(2, 10, 5, 0, 20, 7, 0, 12, 0, 1);
    win(3,  5, 0, 0, -1, 0, 0, 28, 0, 1);
    // duty 0: nothing driven
    win(4,  5, 10, 0, -1, 0, 0, 0, 0, 1);
    // duty 10 > period 9: first window loses only the lagged sample 0
    win(5, -1, 0, 0, -1, 0, 0, 39, 0, 0);
    win(6,  5, 8, 0, -1, 0, 0, 40, 0, 1);
    win(7,  5, 8, 1, -1, 0, 0, 33, 0, 1);
    // reversal to dir 1: two dead ticks, out_b on ticks 2..7; coincident load at the wrap
    win(8, 39, 4, 1, -1, 0, 0, 0, 24, 0);
    win(9,  5, 10, 0, -1, 0, 0, 0, 16, 1);
    win(10, -1, 0, 0, -1, 0, 0, 31, 0, 0);

    repeat (5) @(negedge clk);
    bus.period_in = 8'd9; bus.duty_in = 8'd3; bus.dir_in = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    check("pre_rst_out_a", int'(bus.out_a), 1);
    check("pre_rst_pending", int'(bus.pending), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_out_a", int'(bus.out_a), 0);
    check("async_rst_out_b", int'(bus.out_b), 0);
    check("async_rst_cs", int'(bus.cycle_start), 0);
    check("async_rst_pending", int'(bus.pending), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    ha = 0; hb = 0; ncs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ha  += int'(bus.out_a);
      hb  += int'(bus.out_b);
      ncs += int'(bus.cycle_start);
    end
    check("post_rst_out_a", ha, 0);
    check("post_rst_out_b", hb, 0);
    check("post_rst_wraps", ncs, 5);
    check("post_rst_pending", int'(bus.pending), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
